trace_event_sequencer: RTL

- Sits directly upstream of the DPI adapter that drives the simulation-control and trace DPI-C calls (halt, mtrace address/ls-type, ftrace jal/jalr).
- Takes one retired instruction per cycle from the core's commit stage and classifies it as MEM, JAL, JALR, EBREAK or NONE.
- Queues classified events in a small FIFO and replays them as clean, edge-separated pulses, so every event produces exactly one DPI call even when events arrive back-to-back.

---
 rtl/trace_event_sequencer.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/trace_event_sequencer.sv
// sync_fifo: generic single-clock FIFO, zero-latency head (pop_dat_o shows the oldest entry).
// Push is refused when full unless a pop happens in the same cycle; pop is ignored when empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_vld_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_rdy_i,
    output logic [WIDTH-1:0] pop_dat_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full_o    = (cnt_q == FULL_CNT);
    assign empty_o   = (cnt_q == '0);
    assign pop_dat_o = mem_q[rd_ptr_q];
    assign do_pop    = pop_rdy_i && !empty_o;
    assign do_push   = push_vld_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        cnt_d    = cnt_q;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end
endmodule

// trace_event_sequencer: classifies commits, queues them, replays each as an edge-separated DPI pulse.
// Output 1 cycle after enqueue into an empty queue, one event per 3 cycles; commit_ready drops on full or after ebreak.
module trace_event_sequencer #(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [3:0] LS_NONE    = 4'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        commit_valid,
    output logic        commit_ready,
    input  logic [31:0] commit_inst,
    input  logic [3:0]  commit_ls_type,
    input  logic [31:0] commit_mem_addr,
    output logic        halt,
    output logic [31:0] address,
    output logic [3:0]  lsType,
    output logic        inst_jal,
    output logic        inst_jalr,
    output logic        busy
);
    localparam logic [2:0] CLS_NONE   = 3'd0;
    localparam logic [2:0] CLS_MEM    = 3'd1;
    localparam logic [2:0] CLS_JAL    = 3'd2;
    localparam logic [2:0] CLS_JALR   = 3'd3;
    localparam logic [2:0] CLS_EBREAK = 3'd4;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_PULSE  = 2'd1;
    localparam logic [1:0] ST_GAP    = 2'd2;
    localparam logic [1:0] ST_HALTED = 2'd3;

    localparam int EW = 3 + 32 + 4;

    logic [2:0]    cls;
    logic          accept, push;
    logic          ebreak_seen_q, ebreak_seen_d;
    logic          fifo_full, fifo_empty, pop;
    logic [EW-1:0] head;
    logic [2:0]    head_cls;
    logic [31:0]   head_addr;
    logic [3:0]    head_ls;

    logic [1:0]    state_q, state_d;
    logic          halt_q, halt_d;
    logic [31:0]   address_q, address_d;
    logic [3:0]    ls_q, ls_d;
    logic          jal_q, jal_d;
    logic          jalr_q, jalr_d;

    // Priority order matters: ebreak must win over any ls_type the core reports.
    always_comb begin
        cls = CLS_NONE;
        if (commit_inst == 32'h0010_0073) begin
            cls = CLS_EBREAK;
        end else if (commit_inst[6:0] == 7'b1101111) begin
            cls = CLS_JAL;
        end else if (commit_inst[6:0] == 7'b1100111 && commit_inst[14:12] == 3'b000) begin
            cls = CLS_JALR;
        end else if (commit_ls_type != LS_NONE) begin
            cls = CLS_MEM;
        end
    end

    assign commit_ready  = !fifo_full && !ebreak_seen_q;
    assign accept        = commit_valid && commit_ready;
    assign push          = accept && (cls != CLS_NONE);
    assign ebreak_seen_d = ebreak_seen_q || (accept && cls == CLS_EBREAK);
    assign pop           = (state_q == ST_IDLE) && !fifo_empty;
    assign {head_cls, head_addr, head_ls} = head;

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_evt_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_vld_i (push),
        .push_dat_i ({cls, commit_mem_addr, commit_ls_type}),
        .pop_rdy_i  (pop),
        .pop_dat_o  (head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    // Pulse outputs default low so every pulse lasts exactly the PULSE cycle.
    always_comb begin
        state_d   = state_q;
        halt_d    = halt_q;
        address_d = address_q;
        ls_d      = LS_NONE;
        jal_d     = 1'b0;
        jalr_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    state_d = ST_PULSE;
                    case (head_cls)
                        CLS_MEM: begin
                            address_d = head_addr;
                            ls_d      = head_ls;
                        end
                        CLS_JAL:    jal_d  = 1'b1;
                        CLS_JALR:   jalr_d = 1'b1;
                        CLS_EBREAK: begin
                            halt_d  = 1'b1;
                            state_d = ST_HALTED;
                        end
                        default: ;
                    endcase
                end
            end
            ST_PULSE:  state_d = ST_GAP;
            ST_GAP:    state_d = ST_IDLE;
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ebreak_seen_q <= 1'b0;
            state_q       <= ST_IDLE;
            halt_q        <= 1'b0;
            address_q     <= 32'h0;
            ls_q          <= LS_NONE;
            jal_q         <= 1'b0;
            jalr_q        <= 1'b0;
        end else begin
            ebreak_seen_q <= ebreak_seen_d;
            state_q       <= state_d;
            halt_q        <= halt_d;
            address_q     <= address_d;
            ls_q          <= ls_d;
            jal_q         <= jal_d;
            jalr_q        <= jalr_d;
        end
    end

    assign halt      = halt_q;
    assign address   = address_q;
    assign lsType    = ls_q;
    assign inst_jal  = jal_q;
    assign inst_jalr = jalr_q;
    assign busy      = !fifo_empty || (state_q == ST_PULSE) || (state_q == ST_GAP);
endmodule
